// File: rtl/fft_agu_pkg.sv
// Shared definitions for the in-place radix-2 DIT FFT address generator:
// FSM state encoding, a constant clog2 helper and the parameter sanity check.
package fft_agu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int MIN_ADDR_WIDTH = 2;
  localparam int MIN_PIPE_LAT   = 1;

  // Elaboration-time ceil(log2(value)); clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int addr_width, input int pipe_lat);
    return (addr_width >= MIN_ADDR_WIDTH) && (pipe_lat >= MIN_PIPE_LAT);
  endfunction

endpackage

// File: rtl/addr_delay_line.sv
// Fixed-depth shift register that retimes read-side address/valid words to
// the write-back side. Holds while en is low; clr flushes every tap to zero.
module addr_delay_line
  import fft_agu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[i] <= '0;
      end
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fft_agu_pipe.sv
// Pipelined address generator for an in-place radix-2 DIT FFT: issues one
// butterfly read per cycle and replays each address PIPE_LAT cycles later as a write.
module fft_agu_pipe
  import fft_agu_pkg::*;
#(
  parameter int  ADDR_WIDTH = 3,
  parameter int  PIPE_LAT   = 4,
  localparam int STAGE_W    = clog2(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] addr_A_read,
  output logic [ADDR_WIDTH-1:0] addr_B_read,
  output logic [ADDR_WIDTH-1:0] addr_Twiddle,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] addr_A_write,
  output logic [ADDR_WIDTH-1:0] addr_B_write,
  output logic                  wr_en,
  output logic [STAGE_W-1:0]    stage,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  // Control protocol: start is sampled only in IDLE; busy covers accept..done;
  // done is a one-cycle pulse. stall freezes every register for the cycle and
  // masks the rd_valid/wr_en/done pulses so nothing is seen twice.

  localparam int HALF  = 1 << (ADDR_WIDTH - 1);
  localparam int J_W   = ADDR_WIDTH - 1;
  localparam int CNT_W = clog2(PIPE_LAT + 1);
  localparam int DL_W  = 2 * ADDR_WIDTH + 1;

  if (!params_ok(ADDR_WIDTH, PIPE_LAT)) begin : g_param_error
    $error("fft_agu_pipe: ADDR_WIDTH must be >= 2 and PIPE_LAT >= 1");
  end

  logic [1:0]         state;
  logic [STAGE_W-1:0] s_q;
  logic [J_W-1:0]     j_q;
  logic [CNT_W-1:0]   drain_q;

  logic [ADDR_WIDTH-1:0] a_rd_q;
  logic [ADDR_WIDTH-1:0] b_rd_q;
  logic [ADDR_WIDTH-1:0] k_rd_q;
  logic                  rd_v_q;
  logic [STAGE_W-1:0]    stage_q;
  logic                  busy_q;
  logic                  done_q;

  logic [3*ADDR_WIDTH-1:0] addr_next;
  logic [DL_W-1:0]         dl_in;
  logic [DL_W-1:0]         dl_out;

  // Butterfly j of stage s: group g, position p inside the group; the
  // partner sits 2^s above, and the twiddle exponent is p scaled to N.
  function automatic logic [3*ADDR_WIDTH-1:0] bfly_addr(
    input logic [STAGE_W-1:0] s,
    input logic [J_W-1:0]     j
  );
    logic [ADDR_WIDTH-1:0] jx;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] p;
    logic [ADDR_WIDTH-1:0] g;
    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] b;
    logic [ADDR_WIDTH-1:0] k;
    int                    si;
    si   = int'(s);
    jx   = {1'b0, j};
    mask = (ADDR_WIDTH'(1) << si) - ADDR_WIDTH'(1);
    p    = jx & mask;
    g    = jx >> si;
    a    = (g << (si + 1)) | p;
    b    = a + (ADDR_WIDTH'(1) << si);
    k    = p << (ADDR_WIDTH - 1 - si);
    return {a, b, k};
  endfunction

  assign addr_next = bfly_addr(s_q, j_q);

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
    end else if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ISSUE;
            s_q   <= '0;
            j_q   <= '0;
          end
        end
        ST_ISSUE: begin
          if (j_q == J_W'(HALF - 1)) begin
            state   <= ST_DRAIN;
            drain_q <= '0;
          end else begin
            j_q <= j_q + J_W'(1);
          end
        end
        ST_DRAIN: begin
          // Wait until the last write of this stage has left the delay line
          // before the next stage may read the same locations.
          if (drain_q == CNT_W'(PIPE_LAT - 1)) begin
            if (s_q == STAGE_W'(ADDR_WIDTH - 1)) begin
              state <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
              s_q   <= s_q + STAGE_W'(1);
              j_q   <= '0;
            end
          end else begin
            drain_q <= drain_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_rd_q  <= '0;
      b_rd_q  <= '0;
      k_rd_q  <= '0;
      rd_v_q  <= 1'b0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!stall) begin
      rd_v_q <= (state == ST_ISSUE);
      if (state == ST_ISSUE) begin
        a_rd_q  <= addr_next[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
        b_rd_q  <= addr_next[2*ADDR_WIDTH-1:ADDR_WIDTH];
        k_rd_q  <= addr_next[ADDR_WIDTH-1:0];
        stage_q <= s_q;
      end
      busy_q <= (state == ST_ISSUE) || (state == ST_DRAIN);
      done_q <= (state == ST_DONE);
    end
  end

  // Fed from the registered read side, so a read seen in cycle c is
  // written in cycle c + PIPE_LAT.
  assign dl_in = {a_rd_q, b_rd_q, rd_v_q};

  addr_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (DL_W)
  ) u_delay (
    .clk  (clk),
    .clr  (clr),
    .en   (!stall),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign addr_A_read  = a_rd_q;
  assign addr_B_read  = b_rd_q;
  assign addr_Twiddle = k_rd_q;
  assign rd_valid     = rd_v_q & ~stall;
  assign addr_A_write = dl_out[DL_W-1:ADDR_WIDTH+1];
  assign addr_B_write = dl_out[ADDR_WIDTH:1];
  assign wr_en        = dl_out[0] & ~stall;
  assign stage        = stage_q;
  assign busy         = busy_q;
  assign done         = done_q & ~stall;
  assign dbg_state    = state;

endmodule

// File: tb/tb_fft_agu_pipe.sv
// Directed-plus-random bench for fft_agu_pipe across four parameter sets,
// checked against an arithmetic model of the FFT schedule.
module tb_fft_agu_pipe;
  import fft_agu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clr;
  logic start;
  logic stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic [2:0] a_rd_s [3];
  logic [2:0] b_rd_s [3];
  logic [2:0] k_s    [3];
  logic [2:0] a_wr_s [3];
  logic [2:0] b_wr_s [3];
  logic [1:0] st_s   [3];
  logic [1:0] dbg_s  [3];
  logic       rv_s   [3];
  logic       we_s   [3];
  logic       busy_s [3];
  logic       done_s [3];

  logic [4:0] a_rd3, b_rd3, k3, a_wr3, b_wr3;
  logic [2:0] st3;
  logic [1:0] dbg3;
  logic       rv3, we3, busy3, done3;

  fft_agu_pipe #(.ADDR_WIDTH(3), .PIPE_LAT(4)) dut0 (
    .clk(clk), .clr(clr), .start(start), .stall(stall),
    .addr_A_read(a_rd_s[0]), .addr_B_read(b_rd_s[0]), .addr_Twiddle(k_s[0]),
    .rd_valid(rv_s[0]), .addr_A_write(a_wr_s[0]), .addr_B_write(b_wr_s[0]),
    .wr_en(we_s[0]), .stage(st_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .dbg_state(dbg_s[0]));

  fft_agu_pipe #(.ADDR_WIDTH(3), .PIPE_LAT(1)) dut1 (
    .clk(clk), .clr(clr), .start(start), .stall(stall),
    .addr_A_read(a_rd_s[1]), .addr_B_read(b_rd_s[1]), .addr_Twiddle(k_s[1]),
    .rd_valid(rv_s[1]), .addr_A_write(a_wr_s[1]), .addr_B_write(b_wr_s[1]),
    .wr_en(we_s[1]), .stage(st_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .dbg_state(dbg_s[1]));

  fft_agu_pipe #(.ADDR_WIDTH(3), .PIPE_LAT(7)) dut2 (
    .clk(clk), .clr(clr), .start(start), .stall(stall),
    .addr_A_read(a_rd_s[2]), .addr_B_read(b_rd_s[2]), .addr_Twiddle(k_s[2]),
    .rd_valid(rv_s[2]), .addr_A_write(a_wr_s[2]), .addr_B_write(b_wr_s[2]),
    .wr_en(we_s[2]), .stage(st_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .dbg_state(dbg_s[2]));

  fft_agu_pipe #(.ADDR_WIDTH(5), .PIPE_LAT(3)) dut3 (
    .clk(clk), .clr(clr), .start(start), .stall(stall),
    .addr_A_read(a_rd3), .addr_B_read(b_rd3), .addr_Twiddle(k3),
    .rd_valid(rv3), .addr_A_write(a_wr3), .addr_B_write(b_wr3),
    .wr_en(we3), .stage(st3), .busy(busy3), .done(done3),
    .dbg_state(dbg3));

  // ---------------- observation mux ----------------
  int sel;
  int obs_ard, obs_brd, obs_k, obs_awr, obs_bwr, obs_stage, obs_dbg;
  int obs_rv, obs_we, obs_busy, obs_done;

  always_comb begin
    if (sel == 3) begin
      obs_ard = int'(a_rd3);  obs_brd = int'(b_rd3);  obs_k = int'(k3);
      obs_awr = int'(a_wr3);  obs_bwr = int'(b_wr3);  obs_stage = int'(st3);
      obs_dbg = int'(dbg3);   obs_rv = int'(rv3);     obs_we = int'(we3);
      obs_busy = int'(busy3); obs_done = int'(done3);
    end else begin
      obs_ard = int'(a_rd_s[sel]);  obs_brd = int'(b_rd_s[sel]);  obs_k = int'(k_s[sel]);
      obs_awr = int'(a_wr_s[sel]);  obs_bwr = int'(b_wr_s[sel]);  obs_stage = int'(st_s[sel]);
      obs_dbg = int'(dbg_s[sel]);   obs_rv = int'(rv_s[sel]);     obs_we = int'(we_s[sel]);
      obs_busy = int'(busy_s[sel]); obs_done = int'(done_s[sel]);
    end
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [39:0] exp_q[$];   // {write cycle[15:0], stage[7:0], A[7:0], B[7:0]}
  int log_a[$];
  int log_b[$];
  int log_k[$];

  int tbl_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tbl_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tbl_k[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int aw_of(input int s_el);
    return (s_el == 3) ? 5 : 3;
  endfunction

  function automatic int lat_of(input int s_el);
    case (s_el)
      0:       return 4;
      1:       return 1;
      2:       return 7;
      default: return 3;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_clr();
    @(posedge clk); #1;
    clr = 1'b1; start = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // One transform on instance s_el. mode: 0 plain, 1 directed stalls,
  // 2 random stalls + random start pulses, 3 random start pulses only.
  // done_cyc returns the real cycle (edges after the start edge) of done.
  task automatic run(input int s_el, input int mode, input bit keep_start,
                     output int done_cyc);
    int aw, lat, n2, per, done_nom, stalled, nom, budget;
    int rs, rj, p, ea, eb, ek, t;
    bit st, exp_rv, exp_we;
    logic [39:0] e;
    int first_rd[8];
    int last_wr[8];
    aw = aw_of(s_el);
    lat = lat_of(s_el);
    n2 = 1 << (aw - 1);
    per = n2 + lat;
    done_nom = aw * per + 1;
    budget = 3 * done_nom + 40;
    for (int i = 0; i < 8; i++) begin
      first_rd[i] = -1;
      last_wr[i] = -1;
    end
    exp_q.delete();
    log_a.delete(); log_b.delete(); log_k.delete();
    sel = s_el;
    done_cyc = -1;
    stalled = 0;
    start = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1;
    start = keep_start;
    @(negedge clk);
    check("cycle0_busy", obs_busy, 0);
    check("cycle0_rd_valid", obs_rv, 0);
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      nom = c - stalled;
      case (mode)
        1:       st = (c == 10 || c == 11 || c == 12 || c == 17 || c == 18);
        2:       st = ($urandom_range(0, 5) == 0);
        default: st = 1'b0;
      endcase
      stall = st;
      if ((mode >= 2) && (nom < done_nom)) start = 1'($urandom_range(0, 1));
      else start = keep_start;
      @(negedge clk);
      if (st) begin
        check("stall_rd_valid", obs_rv, 0);
        check("stall_wr_en", obs_we, 0);
        check("stall_done", obs_done, 0);
        check("stall_busy", obs_busy, int'(nom >= 1 && nom < done_nom));
        stalled++;
      end else begin
        t = nom - 1;
        rs = t / per;
        rj = t % per;
        exp_rv = (nom >= 1) && (rs < aw) && (rj < n2);
        check("rd_valid", obs_rv, int'(exp_rv));
        if (exp_rv && obs_rv == 1) begin
          p  = rj % (1 << rs);
          ea = (rj >> rs) * (1 << (rs + 1)) + p;
          eb = ea + (1 << rs);
          ek = p * (1 << (aw - 1 - rs));
          check("rd_A", obs_ard, ea);
          check("rd_B", obs_brd, eb);
          check("rd_k", obs_k, ek);
          check("stage", obs_stage, rs);
          exp_q.push_back({16'(nom + lat), 8'(rs), 8'(ea), 8'(eb)});
          if (first_rd[rs] < 0) first_rd[rs] = nom;
          log_a.push_back(obs_ard); log_b.push_back(obs_brd); log_k.push_back(obs_k);
        end
        exp_we = 1'b0;
        if (exp_q.size() > 0) exp_we = (int'(exp_q[0][39:24]) == nom);
        check("wr_en", obs_we, int'(exp_we));
        if (exp_we) begin
          e = exp_q.pop_front();
          check("wr_A", obs_awr, int'(e[15:8]));
          check("wr_B", obs_bwr, int'(e[7:0]));
          if (obs_we == 1) last_wr[int'(e[23:16])] = nom;
        end
        check("busy", obs_busy, int'(nom >= 1 && nom < done_nom));
        check("done", obs_done, int'(nom == done_nom));
        if (nom == done_nom) begin
          done_cyc = c;
          break;
        end
      end
    end
    check("run_done_seen", int'(done_cyc >= 0), 1);
    check("writes_drained", exp_q.size(), 0);
    for (int s = 1; s < aw; s++) begin
      check("hazard_order", int'(first_rd[s] > last_wr[s-1] && last_wr[s-1] >= 0), 1);
    end
    stall = 1'b0;
    start = keep_start;
  endtask

  task automatic check_basic_log();
    check("basic_read_count", log_a.size(), 12);
    for (int i = 0; i < 12 && i < log_a.size(); i++) begin
      check("basic_seq_A", log_a[i], tbl_a[i]);
      check("basic_seq_B", log_b[i], tbl_b[i]);
      check("basic_seq_k", log_k[i], tbl_k[i]);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd_A"}, obs_ard, 0);
    check({tag, "_rd_B"}, obs_brd, 0);
    check({tag, "_k"}, obs_k, 0);
    check({tag, "_wr_A"}, obs_awr, 0);
    check({tag, "_wr_B"}, obs_bwr, 0);
    check({tag, "_rd_valid"}, obs_rv, 0);
    check({tag, "_wr_en"}, obs_we, 0);
    check({tag, "_busy"}, obs_busy, 0);
    check({tag, "_done"}, obs_done, 0);
    check({tag, "_stage"}, obs_stage, 0);
    check({tag, "_state"}, obs_dbg, int'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d, d2;
    checks = 0;
    errors = 0;
    sel = 0;
    clr = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_aw3");
    sel = 3;
    #1;
    check_idle_zero("reset_aw5");

    // basic run
    run(0, 0, 1'b0, d);
    check("basic_done_cycle", d, 25);
    check_basic_log();

    // hazard runs with short and long butterfly latency
    pulse_clr();
    run(1, 0, 1'b0, d);
    check("lat1_done_cycle", d, 16);
    pulse_clr();
    run(2, 0, 1'b0, d);
    check("lat7_done_cycle", d, 34);

    // stalls mid stage 1 and during its drain
    pulse_clr();
    run(0, 1, 1'b0, d);
    check("stall_done_cycle", d, 30);
    check_basic_log();

    // clear in cycle 10 of a run
    pulse_clr();
    sel = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check_idle_zero("clr_mid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("clr_mid_no_write", obs_we, 0);
      check("clr_mid_no_read", obs_rv, 0);
    end
    run(0, 0, 1'b0, d);
    check("after_clr_done_cycle", d, 25);
    check_basic_log();

    // start pulses while busy are ignored
    pulse_clr();
    run(0, 3, 1'b0, d);
    check("start_ignored_done_cycle", d, 25);

    // start held high: back-to-back runs with one idle cycle between
    pulse_clr();
    run(0, 0, 1'b1, d);
    run(0, 0, 1'b0, d2);
    check("b2b_first_done", d, 25);
    check("b2b_second_done", d2, 25);

    // scaling: 32 points
    pulse_clr();
    run(3, 0, 1'b0, d);
    check("aw5_done_cycle", d, 96);
    check("aw5_read_count", log_a.size(), 80);
    if (log_a.size() == 80) begin
      check("aw5_last_A", log_a[79], 15);
      check("aw5_last_B", log_b[79], 31);
      check("aw5_last_k", log_k[79], 15);
    end

    // random stalls and start noise
    pulse_clr();
    run(3, 2, 1'b0, d);
    pulse_clr();
    run(2, 2, 1'b0, d);
    pulse_clr();
    run(0, 2, 1'b0, d);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
